// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: double-buffered frame, per-digit dwell
// with an inter-digit blanking gap, internal hex decode, registered active-low drives.
module sseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                      : BLANK_CYCLES;
    localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);
    localparam logic [DigW-1:0] LastDigit = DigW'(NUM_DIGITS - 1);

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StDwell = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DigW-1:0]         digit_q, digit_d;
    logic                    boundary;

    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] pend_din_q, pend_din_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [4*NUM_DIGITS-1:0] act_din_q, act_din_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic [3:0]              nibble;

    // Active-high segment pattern, AA in bit 7 down to AG in bit 1, DP bit 0 clear.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hFC;
            4'h1:    pat = 8'h60;
            4'h2:    pat = 8'hDA;
            4'h3:    pat = 8'hF2;
            4'h4:    pat = 8'h66;
            4'h5:    pat = 8'hB6;
            4'h6:    pat = 8'hBE;
            4'h7:    pat = 8'hE0;
            4'h8:    pat = 8'hFE;
            4'h9:    pat = 8'hF6;
            4'hA:    pat = 8'hEE;
            4'hB:    pat = 8'h3E;
            4'hC:    pat = 8'h9C;
            4'hD:    pat = 8'h7A;
            4'hE:    pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q - CntW'(1);
        digit_d  = digit_q;
        boundary = 1'b0;
        if (cnt_q == '0) begin
            if (state_q == StBlank) begin
                state_d = StDwell;
                cnt_d   = DwellLoad;
            end else begin
                state_d = StBlank;
                cnt_d   = BlankLoad;
                if (digit_q == LastDigit) begin
                    digit_d  = '0;
                    boundary = 1'b1;
                end else begin
                    digit_d = digit_q + DigW'(1);
                end
            end
        end
    end

    // A load on the boundary cycle bypasses the pending buffer and wins over older data.
    always_comb begin
        pending_d  = pending_q;
        pend_din_d = pend_din_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        act_din_d  = act_din_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        if (boundary) begin
            pending_d = 1'b0;
            if (load) begin
                act_din_d = din;
                act_dp_d  = dp_in;
                act_en_d  = en_in;
            end else if (pending_q) begin
                act_din_d = pend_din_q;
                act_dp_d  = pend_dp_q;
                act_en_d  = pend_en_q;
            end
        end else if (load) begin
            pending_d  = 1'b1;
            pend_din_d = din;
            pend_dp_d  = dp_in;
            pend_en_d  = en_in;
        end
    end

    always_comb begin
        nibble = act_din_q[{digit_q, 2'b00} +: 4];
        an_d   = '1;
        seg_d  = 8'hFF;
        if (state_q == StDwell && act_en_q[digit_q]) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_d = ~(hex_to_seg(nibble) | {7'b0, act_dp_q[digit_q]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBlank;
            cnt_q        <= BlankLoad;
            digit_q      <= '0;
            pending_q    <= 1'b0;
            pend_din_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            act_din_q    <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            pend_din_q   <= pend_din_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            act_din_q    <= act_din_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            frame_done_q <= boundary;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: frame-position reference model, directed scenarios
// and randomized loads.
module tb_sseg_scan_ctrl;

    localparam int ND = 8;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SL = BL + DW;
    localparam int P  = ND * SL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] din = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic        pending, frame_done;
    logic [7:0]  an, seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    // Reference model: edges since reset, buffers, and expected registered outputs.
    int          m_n = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pdin = '0, m_adin = '0;
    logic [7:0]  m_pdp = '0, m_pen = '0, m_adp = '0, m_aen = '0;
    logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
    logic        exp_pend = 1'b0, exp_fd = 1'b0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dp_in     (dp_in),
        .en_in     (en_in),
        .load      (load),
        .pending   (pending),
        .frame_done(frame_done),
        .an        (an),
        .seg       (seg)
    );

    // Advance the model over one edge using the current inputs, then step the clock.
    task automatic tick();
        int pos, slot, off;
        if (rst) begin
            m_n = 0; m_pend = 1'b0;
            m_pdin = '0; m_pdp = '0; m_pen = '0;
            m_adin = '0; m_adp = '0; m_aen = '0;
            exp_an = 8'hFF; exp_seg = 8'hFF; exp_fd = 1'b0;
        end else begin
            pos  = m_n % P;
            slot = pos / SL;
            off  = pos % SL;
            if (off >= BL && m_aen[slot]) begin
                exp_an  = ~(8'd1 << slot);
                exp_seg = ~(seg_tab[m_adin[4*slot +: 4]] | {7'd0, m_adp[slot]});
            end else begin
                exp_an  = 8'hFF;
                exp_seg = 8'hFF;
            end
            exp_fd = (pos == P - 1);
            if (pos == P - 1) begin
                if (load) begin
                    m_adin = din; m_adp = dp_in; m_aen = en_in;
                end else if (m_pend) begin
                    m_adin = m_pdin; m_adp = m_pdp; m_aen = m_pen;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pdin = din; m_pdp = dp_in; m_pen = en_in; m_pend = 1'b1;
            end
            m_n++;
        end
        exp_pend = m_pend;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int fd_cnt = 0;
        rst = 1'b1;
        repeat (3) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: an=%h seg=%h pend=%b fd=%b, want FF FF 0 0",
                         an, seg, pending, frame_done);
            end
        end
        rst = 1'b0;
        repeat (100) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}
                || an !== 8'hFF || seg !== 8'hFF) begin
                n_fail++;
                $display("FAIL dark n=%0d: an=%h seg=%h pend=%b fd=%b, want an=%h seg=%h pend=%b fd=%b",
                         m_n, an, seg, pending, frame_done, exp_an, exp_seg, exp_pend, exp_fd);
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        n_checks++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d, want 2", fd_cnt);
        end
    endtask

    task automatic test_load_commit();
        int d0_cnt = 0;
        while (m_n % P != 20) tick();
        din = 32'h89AB_CDEF; dp_in = 8'h01; en_in = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pending: got %b, want 1", pending);
        end
        while (m_n % P != 0) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}) begin
                n_fail++;
                $display("FAIL pre_commit n=%0d: an=%h seg=%h pend=%b fd=%b, want an=%h seg=%h pend=%b fd=%b",
                         m_n, an, seg, pending, frame_done, exp_an, exp_seg, exp_pend, exp_fd);
            end
        end
        n_checks++;
        if ({pending, frame_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL commit_boundary: pend=%b fd=%b, want pend=0 fd=1", pending, frame_done);
        end
        repeat (P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}) begin
                n_fail++;
                $display("FAIL commit_frame n=%0d: an=%h seg=%h pend=%b fd=%b, want an=%h seg=%h pend=%b fd=%b",
                         m_n, an, seg, pending, frame_done, exp_an, exp_seg, exp_pend, exp_fd);
            end
            if (an === 8'hFE) begin
                d0_cnt++;
                n_checks++;
                if (seg !== 8'h70) begin
                    n_fail++;
                    $display("FAIL digit0_seg: got %h, want 70", seg);
                end
            end
            if (an === 8'h7F) begin
                n_checks++;
                if (seg !== 8'h01) begin
                    n_fail++;
                    $display("FAIL digit7_seg: got %h, want 01", seg);
                end
            end
        end
        n_checks++;
        if (d0_cnt != DW) begin
            n_fail++;
            $display("FAIL digit0_dwell: got %0d cycles, want %0d", d0_cnt, DW);
        end
    endtask

    task automatic test_enable_mask();
        int lit [8];
        for (int k = 0; k < 8; k++) lit[k] = 0;
        din = 32'h7654_3210; dp_in = 8'h00; en_in = 8'b1010_1010; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_n % P != 0) tick();
        repeat (P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}) begin
                n_fail++;
                $display("FAIL en_mask n=%0d: an=%h seg=%h pend=%b fd=%b, want an=%h seg=%h pend=%b fd=%b",
                         m_n, an, seg, pending, frame_done, exp_an, exp_seg, exp_pend, exp_fd);
            end
            for (int k = 0; k < 8; k++) if (an === ~(8'd1 << k)) lit[k]++;
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (lit[k] != ((k % 2 == 1) ? DW : 0)) begin
                n_fail++;
                $display("FAIL en_mask_slot%0d: lit %0d cycles, want %0d", k, lit[k],
                         (k % 2 == 1) ? DW : 0);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] prev_an, prev_seg;
        int run = 0;
        bit seen_lit;
        din = $urandom; dp_in = 8'($urandom); en_in = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_n % P != 0) tick();
        prev_an  = an;
        prev_seg = seg;
        seen_lit = (an !== 8'hFF);
        repeat (P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}) begin
                n_fail++;
                $display("FAIL blank_model n=%0d: an=%h seg=%h, want an=%h seg=%h",
                         m_n, an, seg, exp_an, exp_seg);
            end
            if (seg !== prev_seg) begin
                n_checks++;
                if (an !== 8'hFF && prev_an !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL seg_while_lit: seg %h->%h with an %h->%h",
                             prev_seg, seg, prev_an, an);
                end
            end
            if (an === 8'hFF) run++;
            else begin
                if (prev_an === 8'hFF && seen_lit) begin
                    n_checks++;
                    if (run != BL) begin
                        n_fail++;
                        $display("FAIL blank_gap: got %0d dark cycles, want %0d", run, BL);
                    end
                end
                seen_lit = 1'b1;
                run = 0;
            end
            prev_an  = an;
            prev_seg = seg;
        end
    endtask

    task automatic test_collisions();
        en_in = 8'hFF; dp_in = 8'h00;
        din = 32'h1111_1111; load = 1'b1;
        tick();
        din = 32'h2222_2222;
        tick();
        load = 1'b0;
        while (m_n % P != 0) tick();
        repeat (P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}
                || (an !== 8'hFF && seg !== 8'h25)) begin
                n_fail++;
                $display("FAIL two_loads n=%0d: an=%h seg=%h pend=%b, want an=%h seg=%h pend=%b",
                         m_n, an, seg, pending, exp_an, exp_seg, exp_pend);
            end
        end
        while (m_n % P != P - 1) tick();
        din = 32'h3333_3333; load = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if ({pending, frame_done} !== 2'b01) begin
            n_fail++;
            $display("FAIL boundary_load: pend=%b fd=%b, want pend=0 fd=1", pending, frame_done);
        end
        repeat (P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}
                || pending !== 1'b0 || (an !== 8'hFF && seg !== 8'h0D)) begin
                n_fail++;
                $display("FAIL boundary_frame n=%0d: an=%h seg=%h pend=%b, want an=%h seg=%h pend=0",
                         m_n, an, seg, pending, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        din = 32'h4444_4444; en_in = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_n % P != 3 * SL + BL + 1) tick();
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pending: got %b, want 1", pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({an, seg, pending, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: an=%h seg=%h pend=%b fd=%b, want FF FF 0 0",
                     an, seg, pending, frame_done);
        end
        repeat (2 * P) begin
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}
                || an !== 8'hFF) begin
                n_fail++;
                $display("FAIL post_reset_dark n=%0d: an=%h seg=%h pend=%b, want dark",
                         m_n, an, seg, pending);
            end
        end
    endtask

    task automatic test_random();
        repeat (8 * P) begin
            if (load && $urandom_range(0, 1) == 0) load = 1'b1;
            else load = ($urandom_range(0, 15) == 0);
            din   = $urandom;
            dp_in = 8'($urandom);
            en_in = 8'($urandom);
            tick();
            n_checks++;
            if ({an, seg, pending, frame_done} !== {exp_an, exp_seg, exp_pend, exp_fd}) begin
                n_fail++;
                $display("FAIL random n=%0d: an=%h seg=%h pend=%b fd=%b, want an=%h seg=%h pend=%b fd=%b",
                         m_n, an, seg, pending, frame_done, exp_an, exp_seg, exp_pend, exp_fd);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_enable_mask();
        test_blanking();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
